// File: rtl/instr_arb_pkg.sv
// Shared types and default sizes for the instruction-fetch arbiter slice.
package instr_arb_pkg;

  typedef enum logic {
    SRC_CORE   = 1'b0,
    SRC_LOADER = 1'b1
  } src_id_t;

  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MAX_OUT = 4;

endpackage

// File: rtl/instr_fetch_arbiter_if.sv
// Valid/ready request + valid-only in-order response bus between a requester and a memory port.
interface instr_fetch_arbiter_if
  import instr_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/instr_arb_id_fifo.sv
// FIFO of source IDs for outstanding requests; head is visible combinationally for response routing.
module instr_arb_id_fifo
  import instr_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  src_id_t                din,
  output src_id_t                head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  src_id_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  // Full only blocks the write side, so a pop alongside a rejected push still drains.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign count = r_count;
endmodule

// File: rtl/instr_fetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between the core fetch port (m0)
// and the loader (m1); a source-ID FIFO routes in-order responses back to their issuer.
module instr_fetch_arbiter
  import instr_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_arbiter_if.slave  m0,
  instr_fetch_arbiter_if.slave  m1,
  instr_fetch_arbiter_if.master s,
  output logic                  rsp_err
);
  lock_state_t               r_lock;
  src_id_t                   r_lock_src;
  src_id_t                   r_last_src;
  logic                      r_rsp_err;

  src_id_t                   w_grant;
  logic                      w_grant_valid;
  logic [ADDR_W-1:0]         w_grant_addr;
  logic [DATA_W-1:0]         w_rsp_data;
  logic                      w_full;
  logic                      w_empty;
  src_id_t                   w_head;
  logic                      w_accept;
  logic                      w_pop;
  logic [$clog2(MAX_OUT):0]  w_unused_count;

  // A stalled request keeps its grant; otherwise the master that did not go last wins a tie.
  always_comb begin
    w_grant = (r_last_src == SRC_CORE) ? SRC_LOADER : SRC_CORE;
    if (r_lock == LOCK_HELD)
      w_grant = r_lock_src;
    else if (m0.req_valid && !m1.req_valid)
      w_grant = SRC_CORE;
    else if (m1.req_valid && !m0.req_valid)
      w_grant = SRC_LOADER;
  end

  assign w_grant_valid = (w_grant == SRC_CORE) ? m0.req_valid : m1.req_valid;
  assign w_grant_addr  = (w_grant == SRC_CORE) ? m0.req_addr  : m1.req_addr;

  assign s.req_valid  = w_grant_valid && !w_full;
  assign s.req_addr   = w_grant_addr;
  assign m0.req_ready = (w_grant == SRC_CORE)   && s.req_ready && !w_full;
  assign m1.req_ready = (w_grant == SRC_LOADER) && s.req_ready && !w_full;

  assign w_accept = s.req_valid && s.req_ready;
  assign w_pop    = s.rsp_valid && !w_empty;

  assign w_rsp_data   = s.rsp_data;
  assign m0.rsp_valid = w_pop && (w_head == SRC_CORE);
  assign m1.rsp_valid = w_pop && (w_head == SRC_LOADER);
  assign m0.rsp_data  = w_rsp_data;
  assign m1.rsp_data  = w_rsp_data;
  assign rsp_err      = r_rsp_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lock     <= LOCK_OPEN;
      r_lock_src <= SRC_CORE;
      r_last_src <= SRC_LOADER;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lock     <= LOCK_OPEN;
        r_last_src <= w_grant;
      end else if (s.req_valid) begin
        r_lock     <= LOCK_HELD;
        r_lock_src <= w_grant;
      end
      // A response with nothing outstanding is dropped and flagged until reset.
      if (s.rsp_valid && w_empty) r_rsp_err <= 1'b1;
    end
  end

  instr_arb_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept),
    .pop   (w_pop),
    .din   (w_grant),
    .head  (w_head),
    .empty (w_empty),
    .full  (w_full),
    .count (w_unused_count)
  );
endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Randomised bench for instr_fetch_arbiter: stimulus side predicts grants and queues expected
// responses; a separate monitor pops them as the DUT routes memory responses.
`timescale 1ns/1ps
module tb_instr_fetch_arbiter;
  import instr_arb_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rsp_err;
  always #5 clk = ~clk;

  instr_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  instr_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  instr_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  instr_fetch_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .rsp_err (rsp_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Stimulus knobs and master request queues
  logic [ADDR_W-1:0] m0_q[$];
  logic [ADDR_W-1:0] m1_q[$];
  bit m0_act = 0, m1_act = 0;
  int m0_pct = 100, m1_pct = 100, rdy_pct = 100, lat_lo = 1, lat_hi = 1;
  bit mem_hold = 0, force_rsp = 0;
  logic rst_n_next = 1'b0;

  // Memory model: pending responses in issue order
  int                mem_due[$];
  logic [DATA_W-1:0] mem_dq[$];

  // Scoreboard ring: written by the stimulus side, consumed by the monitor
  bit                exp_src  [256];
  logic [DATA_W-1:0] exp_data [256];
  int wr_ptr = 0, rd_ptr = 0, occ_pre = 0;
  bit err_model = 0;

  // Request-side reference state
  bit stalled = 0, stall_src = 0, last_src = 1;

  function automatic logic [DATA_W-1:0] mem_word(logic [ADDR_W-1:0] a);
    if (a == 32'h8)      return 32'h0000_006F;
    else if (a < 32'h8)  return 32'h0000_0013;
    else                 return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: response routing, drop behaviour and the sticky error flag
  initial begin : monitor
    bit src;
    forever begin
      @(negedge clk);
      occ_pre = wr_ptr - rd_ptr;
      if (!reset) begin
        rd_ptr    = wr_ptr;
        err_model = 0;
      end else begin
        check("rsp_err", rsp_err, err_model);
        if (s_if.rsp_valid && occ_pre > 0) begin
          src = exp_src[rd_ptr[7:0]];
          check("rsp_route", {m1_if.rsp_valid, m0_if.rsp_valid}, src ? 2'b10 : 2'b01);
          check("rsp_data", src ? m1_if.rsp_data : m0_if.rsp_data, exp_data[rd_ptr[7:0]]);
          $display("cycle %0d: response to m%0d data=%08h", cyc, src, exp_data[rd_ptr[7:0]]);
          rd_ptr++;
        end else begin
          check("rsp_quiet", {m1_if.rsp_valid, m0_if.rsp_valid}, 2'b00);
          if (s_if.rsp_valid) begin
            $display("cycle %0d: stray response dropped", cyc);
            err_model = 1;
          end
        end
      end
    end
  end

  task automatic check_req();
    bit p0 = m0_act;
    bit p1 = m1_act;
    bit g, gv, acc;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] d;
    acc = 0;
    ga  = '0;
    if (stalled)        g = stall_src;
    else if (p0 && p1)  g = !last_src;
    else                g = p1 && !p0;
    gv = g ? p1 : p0;
    if (occ_pre >= MAX_OUT) begin
      check("full_block", {s_if.req_valid, m1_if.req_ready, m0_if.req_ready}, 3'b000);
    end else begin
      check("s_req_valid", s_if.req_valid, gv);
      if (gv) begin
        ga = g ? m1_q[0] : m0_q[0];
        check("s_req_addr", s_if.req_addr, ga);
        check("req_ready", {m1_if.req_ready, m0_if.req_ready},
              s_if.req_ready ? (g ? 2'b10 : 2'b01) : 2'b00);
        acc = s_if.req_ready;
      end
    end
    if (acc) begin
      d = mem_word(ga);
      exp_src[wr_ptr[7:0]]  = g;
      exp_data[wr_ptr[7:0]] = d;
      wr_ptr++;
      mem_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
      mem_dq.push_back(d);
      if (g) begin void'(m1_q.pop_front()); m1_act = 0; end
      else   begin void'(m0_q.pop_front()); m0_act = 0; end
      last_src = g;
      stalled  = 0;
      $display("cycle %0d: accept m%0d addr=%08h", cyc, g, ga);
    end else if (gv && occ_pre < MAX_OUT) begin
      stalled   = 1;
      stall_src = g;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    reset = rst_n_next;
    if (!m0_act && m0_q.size() > 0 && $urandom_range(99) < m0_pct) m0_act = 1;
    if (!m1_act && m1_q.size() > 0 && $urandom_range(99) < m1_pct) m1_act = 1;
    m0_if.req_valid = m0_act;
    m0_if.req_addr  = m0_act ? m0_q[0] : '0;
    m1_if.req_valid = m1_act;
    m1_if.req_addr  = m1_act ? m1_q[0] : '0;
    s_if.req_ready  = ($urandom_range(99) < rdy_pct);
    s_if.rsp_valid  = 1'b0;
    s_if.rsp_data   = $urandom;
    if (reset && force_rsp) begin
      s_if.rsp_valid = 1'b1;
      force_rsp      = 0;
    end else if (reset && !mem_hold && mem_due.size() > 0 && mem_due[0] <= cyc) begin
      s_if.rsp_valid = 1'b1;
      s_if.rsp_data  = mem_dq[0];
      void'(mem_due.pop_front());
      void'(mem_dq.pop_front());
    end
    @(negedge clk);
    #2;
    if (reset) check_req();
  endtask

  task automatic do_reset(int n);
    rst_n_next = 1'b0;
    repeat (n) cycle();
    rst_n_next = 1'b1;
    last_src   = 1;
    stalled    = 0;
  endtask

  task automatic drain(int limit);
    int n = 0;
    while ((m0_q.size() > 0 || m1_q.size() > 0 || mem_due.size() > 0 || wr_ptr != rd_ptr)
           && n < limit) begin
      cycle();
      n++;
    end
    if (n >= limit) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", limit);
    end
  endtask

  initial begin : stimulus
    int n;
    m0_if.req_valid = 1'b0; m0_if.req_addr = '0;
    m1_if.req_valid = 1'b0; m1_if.req_addr = '0;
    s_if.req_ready  = 1'b0; s_if.rsp_valid = 1'b0; s_if.rsp_data = '0;
    do_reset(3);

    // Core fetches 0x0/0x4/0x8 back-to-back, memory latency 2
    lat_lo = 2; lat_hi = 2;
    m0_q = '{32'h0, 32'h4, 32'h8};
    drain(200);

    // Both masters continuously valid from a fresh reset: m0 first, then alternate
    do_reset(2);
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 6; i++) begin
      m0_q.push_back(32'h1000 + 32'(i * 4));
      m1_q.push_back(32'h2000 + 32'(i * 4));
    end
    drain(300);

    // m1 stalls for 3 cycles, m0 joins; grant must stay locked on m1
    rdy_pct = 0;
    m1_q.push_back(32'h300);
    repeat (3) cycle();
    m0_q.push_back(32'h400);
    repeat (2) cycle();
    rdy_pct = 100;
    drain(200);

    // Fill to MAX_OUT with responses held, then release: pop and blocked push share a cycle
    mem_hold = 1;
    for (int i = 0; i < 5; i++) m0_q.push_back(32'h500 + 32'(i * 4));
    repeat (10) cycle();
    mem_hold = 0;
    drain(200);

    // Stray response with nothing outstanding
    force_rsp = 1;
    repeat (4) cycle();

    // Random traffic
    m0_pct = 60; m1_pct = 60; rdy_pct = 70; lat_lo = 1; lat_hi = 5;
    for (int i = 0; i < 40; i++) begin
      m0_q.push_back($urandom & 32'hFFFF_FFFC);
      m1_q.push_back($urandom & 32'hFFFF_FFFC);
    end
    drain(3000);

    // Reset with requests in flight; late responses must be dropped and flagged
    do_reset(2);
    m0_pct = 100; rdy_pct = 100; lat_lo = 10; lat_hi = 14;
    for (int i = 0; i < 3; i++) m0_q.push_back(32'h700 + 32'(i * 4));
    n = 0;
    while (m0_q.size() > 0 && n < 50) begin cycle(); n++; end
    do_reset(1);
    drain(200);
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_arbiter.md
# instr_fetch_arbiter

Shares one instruction-memory port between two requesters: master 0 is the MR1 fetch port (instr_req_*/instr_rsp_*) and master 1 is the program loader/debug reader. Requests use the MR1 valid/ready request and valid-only in-order response protocol on every side. The block performs round-robin arbitration with grant locking and tracks outstanding requests in a source-ID FIFO, so each response is routed back to the master that issued it.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 32, response data width
- MAX_OUT, 4, maximum outstanding requests; power of 2, ≥2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low; clock clk
- m0_req_valid  in  1  core fetch request valid
- m0_req_ready  out  1  core fetch request accepted
- m0_req_addr  in  ADDR_W  core fetch address
- m0_rsp_valid  out  1  response for master 0
- m0_rsp_data  out  DATA_W  response data
- m1_req_valid / m1_req_ready / m1_req_addr / m1_rsp_valid / m1_rsp_data: same as m0, for the loader
- s_req_valid  out  1  request to instruction memory
- s_req_ready  in  1  memory accepts request
- s_req_addr  out  ADDR_W  selected address
- s_rsp_valid  in  1  memory response valid, in order, no backpressure
- s_rsp_data  in  DATA_W  memory response data
- rsp_err  out  1  sticky: a response arrived with nothing outstanding

## Operation
- Handshake: a transfer occurs on a side when valid && ready on the same clk edge. A master holds valid and addr stable until accepted.
- Full = occupancy == MAX_OUT. When full, s_req_valid = 0 and both mX_req_ready = 0.
- Grant selection (combinational):
  - If lock = 1, the grant is lock_src.
  - Otherwise, if only one master is valid, that master is granted.
  - If both are valid, the master other than last_src is granted.
- s_req_valid = (grant master valid) && !full; s_req_addr = grant master addr.
- mX_req_ready = (grant == X) && s_req_ready && !full.
- Lock: set when s_req_valid && !s_req_ready, with lock_src = grant. Cleared on the accepting handshake. The grant therefore never changes while a request is stalled.
- On acceptance: push grant ID into the FIFO, set last_src = grant, and increment occupancy.
- Response routing (zero-latency, combinational):
  - mX_rsp_valid = s_rsp_valid && !empty && head == X.
  - m0_rsp_data = m1_rsp_data = s_rsp_data.
  - On s_rsp_valid && !empty, pop the FIFO and decrement occupancy.
- Push and pop in the same cycle: occupancy unchanged, FIFO order preserved. This is legal even when full, since full gates only the push side.
- s_rsp_valid while empty: the response is dropped (no mX_rsp_valid), rsp_err is set, and occupancy stays 0 (no underflow).

## Timing
- Request path: combinational, 0 added cycles. Response path: combinational, 0 added cycles.
- s_rsp_valid for a request never arrives in the same cycle as its acceptance; memory latency is ≥1 cycle and unbounded.
- Reset values:
  - FIFO empty, occupancy 0.
  - last_src = 1, so master 0 wins the first contention.
  - lock = 0, rsp_err = 0.
  - mX_rsp_valid = 0; s_req_valid and mX_req_ready follow the inputs.
- Reset mid-operation: all outstanding IDs are discarded, and responses arriving afterwards set rsp_err.
- FIFO read/write pointers are log2(MAX_OUT) bits and wrap modulo MAX_OUT. Occupancy is log2(MAX_OUT)+1 bits.

## Structure
- Package instr_arb_pkg holds:
  - src_id_t: 1-bit enum, SRC_CORE = 0, SRC_LOADER = 1.
  - Default parameter constants.
- Sub-module instr_arb_id_fifo: a src_id_t FIFO of depth MAX_OUT. Ports: push, pop, din, head, empty, full, count.
- The top level contains the arbiter, lock logic and routing.

## Test plan
- Reset release, m0 fetches 0x0, 0x4, 0x8 back-to-back with s_req_ready=1 and memory latency 2 -> three accepts on consecutive cycles; m0_rsp_valid returns three times in order with data 0x13, 0x13, 0x6F; m1_rsp_valid stays 0.
- Both masters valid continuously, s_req_ready=1 -> grants alternate m0, m1, m0, m1 starting with m0; responses are routed to the matching master in the same order.
- m1 valid with s_req_ready=0 for 3 cycles, then m0 also asserts -> s_req_addr stays at m1's address and lock holds; m1 is accepted when ready rises, then m0 is granted.
- MAX_OUT=4, four accepted requests with no responses -> s_req_valid=0 and both readies 0; a response plus a new request in the same cycle -> pop succeeds, push is blocked that cycle and accepted the next.
- s_rsp_valid pulse with nothing outstanding -> no mX_rsp_valid, rsp_err=1 and stays 1 until reset is asserted low.
